// File: rtl/pc_request_unit.sv
// pc_request_unit: PC enable, control-flow steering and dcache request sequencing.
// Build with PC_REQ_PERF_EN defined to add the saturating stall counter.
module pc_request_unit #(
    parameter int WORD_W  = 32,
    parameter int JADDR_W = 26,
    parameter int PERF_W  = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               halt_in,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [1:0]         br_type,
    input  logic               br_eq,
    input  logic [1:0]         jump_ctl,
    input  logic [WORD_W-1:0]  imm_in,
    input  logic [JADDR_W-1:0] jaddr_in,
    input  logic [WORD_W-1:0]  rs_val,
    output logic               pcen,
    output logic               branch,
    output logic [1:0]         jump,
    output logic [WORD_W-1:0]  imm,
    output logic [JADDR_W-1:0] jaddr,
    output logic [WORD_W-1:0]  regtarget,
    output logic               dREN,
    output logic               dWEN,
    output logic               halted,
    output logic [PERF_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DMEM = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state, state_n;
    logic   mem;

    assign mem = mem_rd | mem_wr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN: begin
                if (ihit & halt_in)  state_n = HALT;
                else if (ihit & mem) state_n = DMEM;
            end
            DMEM:    if (dhit) state_n = RUN;
            HALT:    state_n = HALT;
            default: state_n = RUN;
        endcase
    end

    always_comb begin
        pcen = 1'b0;
        case (state)
            RUN:     pcen = ihit & ~halt_in & ~mem;
            DMEM:    pcen = dhit;
            default: pcen = 1'b0;
        endcase
    end

    // Store wins when a decode flags both read and write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dREN <= 1'b0;
            dWEN <= 1'b0;
        end else if (state == RUN && state_n == DMEM) begin
            dWEN <= mem_wr;
            dREN <= mem_rd & ~mem_wr;
        end else if (state == DMEM && dhit) begin
            dREN <= 1'b0;
            dWEN <= 1'b0;
        end
    end

    assign halted = (state == HALT);

    assign branch = ((br_type == 2'b01) & br_eq)
                  | ((br_type == 2'b10) & ~br_eq);
    assign jump      = jump_ctl;
    assign imm       = imm_in;
    assign jaddr     = jaddr_in;
    assign regtarget = rs_val;

`ifdef PC_REQ_PERF_EN
    logic              stall_now;
    logic [PERF_W-1:0] cnt;

    assign stall_now = ((state == RUN) & ~ihit)
                     | ((state == DMEM) & ~dhit);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (stall_now && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_request_unit.sv
// tb_pc_request_unit: directed scenarios plus randomized run against
// a cycle-level behavioural model of the PC request rules.
module tb_pc_request_unit;

    localparam int WORD_W  = 32;
    localparam int JADDR_W = 26;
    localparam int PERF_W  = 32;

    logic               CLK = 1'b0;
    logic               RST;
    logic               ihit, dhit, halt_in, mem_rd, mem_wr;
    logic [1:0]         br_type;
    logic               br_eq;
    logic [1:0]         jump_ctl;
    logic [WORD_W-1:0]  imm_in;
    logic [JADDR_W-1:0] jaddr_in;
    logic [WORD_W-1:0]  rs_val;
    logic               pcen, branch;
    logic [1:0]         jump;
    logic [WORD_W-1:0]  imm;
    logic [JADDR_W-1:0] jaddr;
    logic [WORD_W-1:0]  regtarget;
    logic               dREN, dWEN, halted;
    logic [PERF_W-1:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 = executing, 1 = waiting on data, 2 = halted
    int                m_mode;
    logic              m_ren, m_wen;
    logic [PERF_W-1:0] m_stall;

    pc_request_unit #(
        .WORD_W (WORD_W),
        .JADDR_W(JADDR_W),
        .PERF_W (PERF_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ihit     (ihit),
        .dhit     (dhit),
        .halt_in  (halt_in),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .br_type  (br_type),
        .br_eq    (br_eq),
        .jump_ctl (jump_ctl),
        .imm_in   (imm_in),
        .jaddr_in (jaddr_in),
        .rs_val   (rs_val),
        .pcen     (pcen),
        .branch   (branch),
        .jump     (jump),
        .imm      (imm),
        .jaddr    (jaddr),
        .regtarget(regtarget),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .halted   (halted),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic m_pcen();
        if (m_mode == 0) return ihit && !halt_in && !mem_rd && !mem_wr;
        if (m_mode == 1) return dhit;
        return 1'b0;
    endfunction

    function automatic logic m_branch();
        return (br_type == 2'd1 && br_eq) || (br_type == 2'd2 && !br_eq);
    endfunction

    function automatic logic [PERF_W-1:0] m_stall_out();
`ifdef PC_REQ_PERF_EN
        return m_stall;
`else
        return '0;
`endif
    endfunction

    task automatic drive(input logic ih, input logic dh, input logic hl,
                         input logic rd, input logic wr);
        ihit = ih; dhit = dh; halt_in = hl; mem_rd = rd; mem_wr = wr;
    endtask

    // Apply the rules for the upcoming edge to the model, then clock.
    task automatic tick();
        logic stall;
        stall = 1'b0;
        if (m_mode == 0) begin
            stall = !ihit;
            if (ihit && halt_in) m_mode = 2;
            else if (ihit && (mem_rd || mem_wr)) begin
                m_mode = 1;
                m_wen  = mem_wr;
                m_ren  = mem_rd && !mem_wr;
            end
        end else if (m_mode == 1) begin
            stall = !dhit;
            if (dhit) begin
                m_mode = 0;
                m_ren  = 1'b0;
                m_wen  = 1'b0;
            end
        end
        if (stall && m_stall != {PERF_W{1'b1}}) m_stall = m_stall + 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        br_type = 0; br_eq = 0; jump_ctl = 0;
        imm_in = 0; jaddr_in = 0; rs_val = 0;
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_mode = 0; m_ren = 0; m_wen = 0; m_stall = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        if (pcen !== 1'b0) begin
            $display("FAIL reset_pcen got %0b want 0", pcen); n_fail++;
        end
        n_tests++;
        if ({dREN, dWEN} !== 2'b00) begin
            $display("FAIL reset_req got %b want 00", {dREN, dWEN}); n_fail++;
        end
        n_tests++;
        if (halted !== 1'b0) begin
            $display("FAIL reset_halted got %0b want 0", halted); n_fail++;
        end
        n_tests++;
        if (stall_cnt !== '0) begin
            $display("FAIL reset_stall got %0d want 0", stall_cnt); n_fail++;
        end
        n_tests++;
        tick();
    endtask

    task automatic test_branch();
        drive(1, 0, 0, 0, 0);
        br_type = 2'b01; br_eq = 1'b1; jump_ctl = 2'b11;
        imm_in = 32'hFFFF_FFF0; jaddr_in = 26'h2AB_CDEF; rs_val = 32'h1234_5678;
        #2;
        if (pcen !== 1'b1) begin
            $display("FAIL br_pcen got %0b want 1", pcen); n_fail++;
        end
        n_tests++;
        if (branch !== 1'b1) begin
            $display("FAIL beq_taken got %0b want 1", branch); n_fail++;
        end
        n_tests++;
        if ({jump, imm, jaddr, regtarget} !==
            {2'b11, 32'hFFFF_FFF0, 26'h2AB_CDEF, 32'h1234_5678}) begin
            $display("FAIL passthru got %h/%h/%h/%h want 3/fffffff0/2abcdef/12345678",
                     jump, imm, jaddr, regtarget);
            n_fail++;
        end
        n_tests++;
        br_type = 2'b10;
        #1;
        if (branch !== 1'b0) begin
            $display("FAIL bne_eq got %0b want 0", branch); n_fail++;
        end
        n_tests++;
        br_eq = 1'b0;
        #1;
        if (branch !== 1'b1) begin
            $display("FAIL bne_ne got %0b want 1", branch); n_fail++;
        end
        n_tests++;
        br_type = 2'b11;
        #1;
        if (branch !== 1'b0) begin
            $display("FAIL br_reserved got %0b want 0", branch); n_fail++;
        end
        n_tests++;
        tick();
    endtask

    task automatic test_load();
        drive(1, 0, 0, 1, 0);
        #2;
        if (pcen !== 1'b0) begin
            $display("FAIL ld_issue_pcen got %0b want 0", pcen); n_fail++;
        end
        n_tests++;
        tick();
        if ({dREN, dWEN} !== 2'b10) begin
            $display("FAIL ld_req got %b want 10", {dREN, dWEN}); n_fail++;
        end
        n_tests++;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            #2;
            if (pcen !== 1'b0 || dREN !== 1'b1) begin
                $display("FAIL ld_wait%0d got pcen=%0b dREN=%0b want 0/1",
                         i, pcen, dREN);
                n_fail++;
            end
            n_tests++;
            tick();
        end
        drive(0, 1, 0, 0, 0);
        #2;
        if (pcen !== 1'b1) begin
            $display("FAIL ld_dhit_pcen got %0b want 1", pcen); n_fail++;
        end
        n_tests++;
        tick();
        if ({dREN, dWEN} !== 2'b00) begin
            $display("FAIL ld_clear got %b want 00", {dREN, dWEN}); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_store_priority();
        drive(1, 0, 0, 1, 1);
        tick();
        if ({dREN, dWEN} !== 2'b01) begin
            $display("FAIL st_prio got %b want 01", {dREN, dWEN}); n_fail++;
        end
        n_tests++;
        drive(0, 1, 0, 0, 0);
        tick();
        if ({dREN, dWEN} !== 2'b00) begin
            $display("FAIL st_clear got %b want 00", {dREN, dWEN}); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_stall_count();
        logic [PERF_W-1:0] want;
        do_reset();
`ifdef PC_REQ_PERF_EN
        want = 5;
`else
        want = 0;
`endif
        for (int i = 0; i < 5; i++) tick();
        if (stall_cnt !== want || stall_cnt !== m_stall_out()) begin
            $display("FAIL stall5 got %0d want %0d", stall_cnt, want); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_halt();
        drive(1, 0, 1, 0, 0);
        #2;
        if (pcen !== 1'b0) begin
            $display("FAIL halt_pcen got %0b want 0", pcen); n_fail++;
        end
        n_tests++;
        tick();
        if (halted !== 1'b1) begin
            $display("FAIL halted_set got %0b want 1", halted); n_fail++;
        end
        n_tests++;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, i[0], i[1], i[2]);
            #2;
            if ({pcen, dREN, dWEN, halted} !== 4'b0001) begin
                $display("FAIL halt_hold%0d got %b want 0001", i,
                         {pcen, dREN, dWEN, halted});
                n_fail++;
            end
            n_tests++;
            tick();
        end
        do_reset();
        #2;
        if (halted !== 1'b0) begin
            $display("FAIL halt_rst got %0b want 0", halted); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_rst_mid_dmem();
        do_reset();
        drive(0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        if (dREN !== 1'b1) begin
            $display("FAIL rst_dmem_pre got %0b want 1", dREN); n_fail++;
        end
        n_tests++;
        #2;
        RST = 1'b1;
        #1;
        if ({dREN, dWEN} !== 2'b00 || stall_cnt !== '0) begin
            $display("FAIL rst_async got req=%b stall=%0d want 00/0",
                     {dREN, dWEN}, stall_cnt);
            n_fail++;
        end
        n_tests++;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_mode = 0; m_ren = 0; m_wen = 0; m_stall = '0;
        drive(1, 0, 0, 0, 0);
        #2;
        if (pcen !== 1'b1) begin
            $display("FAIL rst_run got %0b want 1", pcen); n_fail++;
        end
        n_tests++;
        tick();
    endtask

    task automatic test_random();
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int c = 0; c < 120; c++) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 4) == 0);
                br_type  = 2'($urandom_range(0, 3));
                br_eq    = 1'($urandom_range(0, 1));
                jump_ctl = 2'($urandom_range(0, 3));
                imm_in   = $urandom;
                jaddr_in = 26'($urandom);
                rs_val   = $urandom;
                #2;
                if (pcen !== m_pcen()) begin
                    $display("FAIL rnd_pcen r%0d c%0d got %0b want %0b",
                             run, c, pcen, m_pcen());
                    n_fail++;
                end
                n_tests++;
                if (branch !== m_branch() || jump !== jump_ctl
                    || regtarget !== rs_val) begin
                    $display("FAIL rnd_ctl r%0d c%0d got %0b/%0d want %0b/%0d",
                             run, c, branch, jump, m_branch(), jump_ctl);
                    n_fail++;
                end
                n_tests++;
                if ({dREN, dWEN, halted} !== {m_ren, m_wen, m_mode == 2}) begin
                    $display("FAIL rnd_req r%0d c%0d got %b want %b", run, c,
                             {dREN, dWEN, halted},
                             {m_ren, m_wen, m_mode == 2});
                    n_fail++;
                end
                n_tests++;
                if (stall_cnt !== m_stall_out()) begin
                    $display("FAIL rnd_stall r%0d c%0d got %0d want %0d",
                             run, c, stall_cnt, m_stall_out());
                    n_fail++;
                end
                n_tests++;
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load();
        test_store_priority();
        test_stall_count();
        test_halt();
        test_rst_mid_dmem();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
